ray_norm_ctrl: RTL
==================

Name: ray_norm_ctrl

Overview:
- Initiator side of the divider-cluster normalization interface.
- Accepts a raw RayDirection and computes its length in fixed point: sum of squares, then a bit-serial integer square root.
- Drives the divider cluster's start/direction/len inputs, waits for its result, and returns the normalized direction over a valid/ready handshake.
- Sits between the ray generator and the divider cluster in the ray setup path.

Parameters:
- WIDTH, 16 (`WIDTH): signed component and length width.
- Q_BITS, 12 (`Q_BITS): fractional bits. Default format is Q3.12.
- TIMEOUT_CYCLES, 255: watchdog limit. Used only when RAY_NORM_TIMEOUT_EN is defined.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- reset  in  1  synchronous, active-low reset.
- in_valid  in  1  upstream direction valid.
- in_ready  out  1  upstream ready; high only in IDLE.
- in_dir  in  3*WIDTH  RayDirection {x,y,z}, signed, Q3.12.
- div_start  out  1  one-cycle start pulse to the divider cluster.
- div_dir  out  3*WIDTH  RayDirection dividend to the cluster.
- div_len  out  WIDTH  divisor (length) to the cluster.
- div_ready  in  1  cluster idle (AND of its dividers' ready).
- div_valid  in  1  cluster result valid.
- div_result  in  3*WIDTH  cluster normalized RayDirection.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream ready.
- out_dir  out  3*WIDTH  normalized RayDirection.
- out_zero  out  1  input was the zero vector.
- out_err  out  1  watchdog expired. Tied 0 without the macro.

Behaviour:
- Reset (reset==0 at a clk edge), taking priority over everything, including mid-operation:
  - state returns to IDLE.
  - in_ready=1.
  - div_start, out_valid, out_zero and out_err = 0.
  - out_dir, div_dir and div_len = 0.
  - Any in-flight divider result is ignored: the controller waits for div_ready before the next issue.
- States: IDLE, SQUARE, SQRT, ADJUST, ISSUE, WAIT_BUSY, WAIT_DONE, OUTPUT.
- IDLE:
  - On in_valid && in_ready, latch in_dir into a working register and go to SQUARE.
- SQUARE, 3 cycles, one shared signed multiplier:
  - acc += c*c for x, y, z in turn.
  - acc is unsigned, 2*WIDTH+2 bits, no overflow possible. The format is Q(2*Q_BITS).
- SQRT, WIDTH+1 cycles, radix-2 digit recurrence on acc:
  - Produces root r of WIDTH+1 bits, Q_BITS fractional, truncated (floor).
- ADJUST, 1 cycle:
  - If acc==0: out_dir=0, out_zero=1, go to OUTPUT. The divider is never started.
  - Else if r >= 2^(WIDTH-1): arithmetic-shift the working x, y, z right by 1 and use len=r>>1. This preserves the ratio.
  - Else len=r.
  - Drive div_dir/div_len, which stay stable until leaving WAIT_DONE. Go to ISSUE.
- ISSUE:
  - Wait for div_ready==1, then pulse div_start for exactly 1 cycle and go to WAIT_BUSY.
- WAIT_BUSY:
  - Wait for div_ready==0, then go to WAIT_DONE. This blocks a stale div_valid.
- WAIT_DONE:
  - On div_valid==1, capture div_result into out_dir, set out_zero=0 and go to OUTPUT.
- OUTPUT:
  - out_valid=1; out_dir, out_zero and out_err are held stable.
  - On out_ready, clear out_valid and go to IDLE.
  - in_ready rises the cycle after the handshake; there is no same-cycle reaccept.
- Latency, accept to out_valid: 3 + (WIDTH+1) + 1 + issue/wait cycles + divider latency + 1. Zero-vector case is WIDTH+6 cycles.
- Signed inputs: squaring removes sign. Signs are carried through to the divider unchanged.
- 0x8000 component: squared as 2^30. Legal; handled by the shift path.

Optional Feature:
- Macro RAY_NORM_TIMEOUT_EN.
- Defined:
  - An 8..16-bit counter runs in ISSUE, WAIT_BUSY and WAIT_DONE and clears on each state entry.
  - On reaching TIMEOUT_CYCLES, go to OUTPUT with out_dir = latched raw input (unshifted) and out_err=1.
- Undefined:
  - No counter; the controller waits indefinitely; out_err is tied 0.

Test Plan:
- in_dir={0x3000,0x4000,0x0000} (3,4,0) -> div_len=0x5000, one div_start pulse. out_dir within 1 LSB of {0x0999,0x0CCC,0x0000}, out_zero=0.
- in_dir={0x7000,0x7000,0x7000} -> shift path: div_dir={0x3800,0x3800,0x3800}, div_len=0x60FE. out_dir components within 1 LSB of 0x093C.
- in_dir={0xD000,0,0} (-3.0) -> div_len=0x3000; out_dir.x within 1 LSB of 0xF000 (-1.0).
- in_dir=0 -> out_zero=1, out_dir=0, out_valid after WIDTH+6 cycles, div_start never asserted.
- Hold out_ready=0 for 10 cycles after out_valid -> out_valid/out_dir stable, in_ready=0. Release -> in_ready=1 the next cycle.
- Assert reset=0 during WAIT_DONE, release, issue {0x1000,0,0} -> outputs cleared at reset. New result out_dir.x ~0x1000. With RAY_NORM_TIMEOUT_EN and div_valid held 0: out_err=1 after TIMEOUT_CYCLES.

Source files
------------

// File: rtl/ray_norm_ctrl_if.sv
// rtl/ray_norm_ctrl_if.sv - upstream, divider-cluster and downstream channels of ray_norm_ctrl
interface ray_norm_ctrl_if #(
    parameter int WIDTH = 16
);
    logic                 in_valid;
    logic                 in_ready;
    logic [3*WIDTH-1:0]   in_dir;
    logic                 div_start;
    logic [3*WIDTH-1:0]   div_dir;
    logic [WIDTH-1:0]     div_len;
    logic                 div_ready;
    logic                 div_valid;
    logic [3*WIDTH-1:0]   div_result;
    logic                 out_valid;
    logic                 out_ready;
    logic [3*WIDTH-1:0]   out_dir;
    logic                 out_zero;
    logic                 out_err;

    modport master (
        input  in_valid, in_dir, div_ready, div_valid, div_result, out_ready,
        output in_ready, div_start, div_dir, div_len, out_valid, out_dir, out_zero, out_err
    );

    modport slave (
        output in_valid, in_dir, div_ready, div_valid, div_result, out_ready,
        input  in_ready, div_start, div_dir, div_len, out_valid, out_dir, out_zero, out_err
    );
endinterface

// File: rtl/ray_norm_ctrl.sv
// rtl/ray_norm_ctrl.sv - ray direction length (sum of squares + bit-serial sqrt) and divider-cluster initiator
// Optional watchdog enabled by defining RAY_NORM_TIMEOUT_EN.
module ray_norm_ctrl #(
    parameter int WIDTH          = 16,
    parameter int Q_BITS         = 12,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic           clk,
    input  logic           reset,
    ray_norm_ctrl_if.master bus
);
    localparam int ACC_W  = 2 * WIDTH + 2;
    localparam int ROOT_W = WIDTH + 1;
    localparam int REM_W  = WIDTH + 4;
    localparam int CNT_W  = $clog2(WIDTH + 1);
    localparam int DIR_W  = 3 * WIDTH;

    typedef enum logic [2:0] {
        S_IDLE, S_SQUARE, S_SQRT, S_ADJUST, S_ISSUE, S_WAIT_BUSY, S_WAIT_DONE, S_OUTPUT
    } state_t;

    state_t              state_q, state_d;
    logic [DIR_W-1:0]    dir_q, dir_d, div_dir_q, div_dir_d, out_dir_q, out_dir_d;
    logic [ACC_W-1:0]    acc_q, acc_d, sh_q, sh_d;
    logic [ROOT_W-1:0]   root_q, root_d;
    logic [REM_W-1:0]    rem_q, rem_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0]    div_len_q, div_len_d;
    logic                out_zero_q, out_zero_d, out_err_q, out_err_d;

    logic signed [WIDTH-1:0]   sq_comp;
    logic signed [2*WIDTH-1:0] sq_prod;
    logic [REM_W-1:0]          rem_shift, rem_trial;
    logic                      acc_zero, root_wide, waiting, timeout_hit;

    assign waiting   = (state_q == S_ISSUE) || (state_q == S_WAIT_BUSY) || (state_q == S_WAIT_DONE);
    assign acc_zero  = (acc_q == '0);
    assign root_wide = |root_q[ROOT_W-1:ROOT_W-2];

    // one shared multiplier walks x, y, z while in SQUARE
    always_comb begin
        case (cnt_q)
            CNT_W'(0): sq_comp = $signed(dir_q[DIR_W-1 -: WIDTH]);
            CNT_W'(1): sq_comp = $signed(dir_q[2*WIDTH-1 -: WIDTH]);
            default:   sq_comp = $signed(dir_q[WIDTH-1:0]);
        endcase
    end

    assign sq_prod   = sq_comp * sq_comp;
    assign rem_shift = {rem_q[REM_W-3:0], sh_q[ACC_W-1 -: 2]};
    assign rem_trial = REM_W'({root_q, 2'b01});

`ifdef RAY_NORM_TIMEOUT_EN
    logic [15:0] wd_q, wd_d;
    logic        unused_cfg;

    assign unused_cfg  = |32'(Q_BITS);
    assign wd_d        = (state_d != state_q) ? '0 : wd_q + 16'd1;
    assign timeout_hit = waiting && (wd_q == 16'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (!reset) wd_q <= '0;
        else        wd_q <= wd_d;
    end
`else
    logic unused_cfg;

    assign unused_cfg  = |{32'(Q_BITS), 32'(TIMEOUT_CYCLES), waiting};
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            dir_q      <= '0;
            acc_q      <= '0;
            sh_q       <= '0;
            root_q     <= '0;
            rem_q      <= '0;
            cnt_q      <= '0;
            div_dir_q  <= '0;
            div_len_q  <= '0;
            out_dir_q  <= '0;
            out_zero_q <= 1'b0;
            out_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            dir_q      <= dir_d;
            acc_q      <= acc_d;
            sh_q       <= sh_d;
            root_q     <= root_d;
            rem_q      <= rem_d;
            cnt_q      <= cnt_d;
            div_dir_q  <= div_dir_d;
            div_len_q  <= div_len_d;
            out_dir_q  <= out_dir_d;
            out_zero_q <= out_zero_d;
            out_err_q  <= out_err_d;
        end
    end

    // WAIT_BUSY exists so a result still in flight from before a reset is never taken
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:      if (bus.in_valid)              state_d = S_SQUARE;
            S_SQUARE:    if (cnt_q == CNT_W'(2))        state_d = S_SQRT;
            S_SQRT:      if (cnt_q == CNT_W'(WIDTH))    state_d = S_ADJUST;
            S_ADJUST:    state_d = acc_zero ? S_OUTPUT : S_ISSUE;
            S_ISSUE:     if (bus.div_ready)             state_d = S_WAIT_BUSY;
            S_WAIT_BUSY: if (!bus.div_ready)            state_d = S_WAIT_DONE;
            S_WAIT_DONE: if (bus.div_valid)             state_d = S_OUTPUT;
            S_OUTPUT:    if (bus.out_ready)             state_d = S_IDLE;
            default:     state_d = S_IDLE;
        endcase
        if (timeout_hit && (state_d == state_q)) state_d = S_OUTPUT;
    end

    always_comb begin
        dir_d      = dir_q;
        acc_d      = acc_q;
        sh_d       = sh_q;
        root_d     = root_q;
        rem_d      = rem_q;
        cnt_d      = (state_d != state_q) ? '0 : cnt_q + CNT_W'(1);
        div_dir_d  = div_dir_q;
        div_len_d  = div_len_q;
        out_dir_d  = out_dir_q;
        out_zero_d = out_zero_q;
        out_err_d  = out_err_q;
        case (state_q)
            S_IDLE: if (bus.in_valid) begin
                dir_d      = bus.in_dir;
                acc_d      = '0;
                out_zero_d = 1'b0;
                out_err_d  = 1'b0;
            end
            S_SQUARE: begin
                acc_d  = acc_q + ACC_W'($unsigned(sq_prod));
                sh_d   = acc_d;
                root_d = '0;
                rem_d  = '0;
            end
            S_SQRT: begin
                sh_d = sh_q << 2;
                if (rem_shift >= rem_trial) begin
                    rem_d  = rem_shift - rem_trial;
                    root_d = {root_q[ROOT_W-2:0], 1'b1};
                end else begin
                    rem_d  = rem_shift;
                    root_d = {root_q[ROOT_W-2:0], 1'b0};
                end
            end
            S_ADJUST: begin
                if (acc_zero) begin
                    out_dir_d  = '0;
                    out_zero_d = 1'b1;
                end else if (root_wide) begin
                    // halve both sides so the length fits the divisor width; the ratio is unchanged
                    for (int i = 0; i < 3; i++)
                        div_dir_d[i*WIDTH +: WIDTH] = WIDTH'($signed(dir_q[i*WIDTH +: WIDTH]) >>> 1);
                    div_len_d = root_q[ROOT_W-1:1];
                end else begin
                    div_dir_d = dir_q;
                    div_len_d = root_q[WIDTH-1:0];
                end
            end
            S_WAIT_DONE: if (bus.div_valid) begin
                out_dir_d  = bus.div_result;
                out_zero_d = 1'b0;
            end
            default: ;
        endcase
        if (timeout_hit && (state_d == S_OUTPUT) && !((state_q == S_WAIT_DONE) && bus.div_valid)) begin
            out_dir_d = dir_q;
            out_err_d = 1'b1;
        end
    end

    always_comb begin
        bus.in_ready  = (state_q == S_IDLE);
        bus.out_valid = (state_q == S_OUTPUT);
        bus.div_start = (state_q == S_ISSUE) && bus.div_ready;
        bus.div_dir   = div_dir_q;
        bus.div_len   = div_len_q;
        bus.out_dir   = out_dir_q;
        bus.out_zero  = out_zero_q;
        bus.out_err   = out_err_q;
    end
endmodule
